// File: rtl/apb_requester_if.sv
// Bus bundle for apb_requester: command/response handshake on one side, APB
// requester/completer signals on the other.
interface apb_requester_if #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_SLV = 4
);
  logic                        cmd_valid;
  logic                        cmd_ready;
  logic                        cmd_write;
  logic [ADDR_W-1:0]           cmd_addr;
  logic [DATA_W-1:0]           cmd_wdata;
  logic [DATA_W/8-1:0]         cmd_strb;
  logic                        rsp_valid;
  logic [DATA_W-1:0]           rsp_rdata;
  logic                        rsp_err;
  logic                        rsp_timeout;
  logic [NUM_SLV-1:0]          PSEL;
  logic                        PENABLE;
  logic [ADDR_W-1:0]           PADDR;
  logic                        PWRITE;
  logic [DATA_W-1:0]           PWDATA;
  logic [DATA_W/8-1:0]         PSTRB;
  logic [NUM_SLV-1:0]          PREADY;
  logic [NUM_SLV-1:0]          PSLVERR;
  logic [NUM_SLV*DATA_W-1:0]   PRDATA;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB,
    input  PREADY, PSLVERR, PRDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB,
    output PREADY, PSLVERR, PRDATA
  );
endinterface

// File: rtl/apb_requester.sv
// Single-outstanding APB requester: decodes a command to one of NUM_SLV
// completer regions, runs SETUP/ACCESS with wait-state timeout, returns a response pulse.
//
//   state  | meaning
//   IDLE   | cmd_ready high, waiting for a command
//   SETUP  | PSEL asserted, PENABLE low
//   ACCESS | PSEL and PENABLE high, waiting for PREADY or timeout
//   DECERR | address hit no completer; error response next cycle
module apb_requester #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_SLV = 4,
  parameter int SLV_AW  = 12,
  parameter int TIMEOUT = 16
) (
  input logic              PCLK,
  input logic              PRESET,
  apb_requester_if.master  bus
);
  localparam int IDX_W  = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int WCNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DECERR} state_t;

  state_t              state_q, state_d;
  logic [WCNT_W-1:0]   wait_q, wait_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [NUM_SLV-1:0]  psel_q, psel_d;
  logic                penable_q, penable_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic                pwrite_q, pwrite_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic [STRB_W-1:0]   pstrb_q, pstrb_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic                rsp_timeout_q, rsp_timeout_d;

  logic [IDX_W-1:0]    cmd_idx;
  logic                cmd_decodes;
  logic                accept;
  logic                sel_ready;
  logic                sel_err;
  logic [DATA_W-1:0]   sel_rdata;
  logic [WCNT_W-1:0]   wait_inc;

  // NUM_SLV=1 uses a 1-bit index field; index 1 then falls out as a decode error.
  assign cmd_idx     = bus.cmd_addr[SLV_AW +: IDX_W];
  assign cmd_decodes = (32'(cmd_idx) < NUM_SLV) &&
                       ((bus.cmd_addr >> (SLV_AW + IDX_W)) == '0);
  assign accept      = (state_q == IDLE) && cmd_ready_q && bus.cmd_valid;
  assign sel_ready   = bus.PREADY[idx_q];
  assign sel_err     = bus.PSLVERR[idx_q];
  assign sel_rdata   = bus.PRDATA[int'(idx_q) * DATA_W +: DATA_W];
  assign wait_inc    = wait_q + WCNT_W'(1);

  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    idx_d         = idx_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    paddr_d       = paddr_q;
    pwrite_d      = pwrite_q;
    pwdata_d      = pwdata_q;
    pstrb_d       = pstrb_q;
    cmd_ready_d   = cmd_ready_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = '0;
    rsp_err_d     = 1'b0;
    rsp_timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        if (accept) begin
          cmd_ready_d = 1'b0;
          if (cmd_decodes) begin
            state_d  = SETUP;
            idx_d    = cmd_idx;
            wait_d   = '0;
            psel_d   = NUM_SLV'(1) << cmd_idx;
            paddr_d  = bus.cmd_addr;
            pwrite_d = bus.cmd_write;
            pwdata_d = bus.cmd_wdata;
            pstrb_d  = bus.cmd_write ? bus.cmd_strb : '0;
          end else begin
            state_d = DECERR;
          end
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (sel_ready) begin
          state_d     = IDLE;
          psel_d      = '0;
          penable_d   = 1'b0;
          cmd_ready_d = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_err_d   = sel_err;
          rsp_rdata_d = pwrite_q ? '0 : sel_rdata;
        end else if ((TIMEOUT != 0) && (wait_inc == WCNT_W'(TIMEOUT))) begin
          state_d       = IDLE;
          psel_d        = '0;
          penable_d     = 1'b0;
          cmd_ready_d   = 1'b1;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
        end else begin
          wait_d = wait_inc;
        end
      end
      DECERR: begin
        state_d     = IDLE;
        cmd_ready_d = 1'b1;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q       <= IDLE;
      wait_q        <= '0;
      idx_q         <= '0;
      psel_q        <= '0;
      penable_q     <= 1'b0;
      paddr_q       <= '0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      cmd_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      idx_q         <= idx_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      paddr_q       <= paddr_d;
      pwrite_q      <= pwrite_d;
      pwdata_q      <= pwdata_d;
      pstrb_q       <= pstrb_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;
  assign bus.PSEL        = psel_q;
  assign bus.PENABLE     = penable_q;
  assign bus.PADDR       = paddr_q;
  assign bus.PWRITE      = pwrite_q;
  assign bus.PWDATA      = pwdata_q;
  assign bus.PSTRB       = pstrb_q;
endmodule

// File: tb/tb_apb_requester.sv
// Directed bench for apb_requester: vector table of single transactions with a
// simple completer model, plus reset-at-start and reset-mid-transfer sequences.
module tb_apb_requester;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int NUM_SLV = 4;
  localparam int SLV_AW  = 12;
  localparam int TIMEOUT = 16;
  localparam int NEVER   = 255;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  apb_requester_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_SLV(NUM_SLV)) bus ();

  apb_requester #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_SLV(NUM_SLV),
    .SLV_AW(SLV_AW), .TIMEOUT(TIMEOUT)
  ) dut (
    .PCLK  (clk),
    .PRESET(rst),
    .bus   (bus)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          waits;
    logic        slverr;
    logic [31:0] prdata;
    logic [3:0]  e_psel;
    logic [3:0]  e_pstrb;
    logic        e_err;
    logic        e_to;
    logic [31:0] e_rdata;
    int          e_lat;
    int          e_psel_cyc;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " ctrl"}, 64'({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PSTRB, bus.rsp_valid,
                               bus.rsp_err, bus.rsp_timeout, bus.cmd_ready}), 64'(0));
    check({tag, " paddr"}, 64'(bus.PADDR), 64'(0));
    check({tag, " pwdata"}, 64'(bus.PWDATA), 64'(0));
    check({tag, " rdata"}, 64'(bus.rsp_rdata), 64'(0));
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int  sel;
    int  c;
    int  acc;
    int  psel_cyc;
    bit  done;
    bit  hold_bad;
    sel = -1;
    for (int i = 0; i < NUM_SLV; i++) if (v.e_psel[i]) sel = i;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = v.wr;
    bus.cmd_addr  = v.addr;
    bus.cmd_wdata = v.wdata;
    bus.cmd_strb  = v.strb;
    bus.PREADY    = '1;
    bus.PSLVERR   = '1;
    bus.PRDATA    = {NUM_SLV{32'hBAD0_0BAD}};
    c = 0;
    while (bus.cmd_ready !== 1'b1 && c < 10) begin
      @(negedge clk);
      c++;
    end
    check({tag, " ready"}, 64'(bus.cmd_ready), 64'(1));
    @(negedge clk);
    bus.cmd_write = ~v.wr;
    bus.cmd_addr  = 32'h0000_4000;
    bus.cmd_wdata = ~v.wdata;
    bus.cmd_strb  = ~v.strb;
    c = 1; acc = 0; psel_cyc = 0; done = 1'b0; hold_bad = 1'b0;
    while (!done && c <= 40) begin
      if (bus.rsp_valid === 1'b1) begin
        done = 1'b1;
        bus.cmd_valid = 1'b0;
        check({tag, " latency"}, 64'(c), 64'(v.e_lat));
        check({tag, " rsp_err"}, 64'(bus.rsp_err), 64'(v.e_err));
        check({tag, " rsp_timeout"}, 64'(bus.rsp_timeout), 64'(v.e_to));
        check({tag, " rsp_rdata"}, 64'(bus.rsp_rdata), 64'(v.e_rdata));
        check({tag, " end_psel_penable"}, 64'({bus.PSEL, bus.PENABLE}), 64'(0));
        check({tag, " end_cmd_ready"}, 64'(bus.cmd_ready), 64'(1));
        check({tag, " psel_cycles"}, 64'(psel_cyc), 64'(v.e_psel_cyc));
      end else begin
        if (bus.PSEL != '0) psel_cyc++;
        if (c == 1) begin
          check({tag, " setup_psel"}, 64'(bus.PSEL), 64'(v.e_psel));
          check({tag, " setup_penable"}, 64'(bus.PENABLE), 64'(0));
        end
        if (bus.PENABLE === 1'b1) begin
          acc++;
          if (acc == 1) begin
            check({tag, " paddr"}, 64'(bus.PADDR), 64'(v.addr));
            check({tag, " pwrite"}, 64'(bus.PWRITE), 64'(v.wr));
            check({tag, " pstrb"}, 64'(bus.PSTRB), 64'(v.e_pstrb));
            if (v.wr) check({tag, " pwdata"}, 64'(bus.PWDATA), 64'(v.wdata));
          end
          if (bus.PADDR !== v.addr || bus.PSTRB !== v.e_pstrb || bus.PWRITE !== v.wr ||
              bus.PSEL !== v.e_psel) hold_bad = 1'b1;
          if (sel >= 0) begin
            bus.PREADY[sel]              = (acc > v.waits);
            bus.PSLVERR[sel]             = v.slverr;
            bus.PRDATA[sel*32 +: 32]     = v.prdata;
          end
        end else if (sel >= 0) begin
          bus.PREADY[sel]  = 1'b1;
          bus.PSLVERR[sel] = 1'b1;
        end
        @(negedge clk);
        c++;
      end
    end
    if (!done) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s no_response: rsp_valid not seen in 40 cycles, expected at %0d", tag, v.e_lat);
      bus.cmd_valid = 1'b0;
    end
    check({tag, " access_hold"}, 64'(hold_bad), 64'(0));
    @(negedge clk);
    check({tag, " rsp_pulse"}, 64'({bus.rsp_valid, bus.PSEL}), 64'(0));
  endtask

  vec_t vecs[8];

  initial begin
    int seen;
    vecs[0] = '{1'b1, 32'h0000_1004, 32'hA5A5_5A5A, 4'hF, 0, 1'b0, 32'hFFFF_FFFF,
                4'b0010, 4'hF, 1'b0, 1'b0, 32'h0, 3, 2};
    vecs[1] = '{1'b0, 32'h0000_2010, 32'h1111_1111, 4'hF, 3, 1'b0, 32'hDEAD_BEEF,
                4'b0100, 4'h0, 1'b0, 1'b0, 32'hDEAD_BEEF, 6, 5};
    vecs[2] = '{1'b1, 32'h0000_4000, 32'h2222_2222, 4'hF, 0, 1'b0, 32'h0,
                4'b0000, 4'h0, 1'b1, 1'b0, 32'h0, 2, 0};
    vecs[3] = '{1'b0, 32'h0000_0008, 32'h0, 4'h0, NEVER, 1'b0, 32'h5555_AAAA,
                4'b0001, 4'h0, 1'b1, 1'b1, 32'h0, 18, 17};
    vecs[4] = '{1'b1, 32'h0000_3000, 32'hCAFE_F00D, 4'h5, 1, 1'b1, 32'h7777_7777,
                4'b1000, 4'h5, 1'b1, 1'b0, 32'h0, 4, 3};
    vecs[5] = '{1'b0, 32'h8000_1000, 32'h0, 4'h0, 0, 1'b0, 32'h3333_3333,
                4'b0000, 4'h0, 1'b1, 1'b0, 32'h0, 2, 0};
    vecs[6] = '{1'b0, 32'h0000_3FFC, 32'h0, 4'hC, 0, 1'b0, 32'h1234_5678,
                4'b1000, 4'h0, 1'b0, 1'b0, 32'h1234_5678, 3, 2};
    vecs[7] = '{1'b1, 32'h0000_0FF0, 32'h0BAD_CAFE, 4'h3, 2, 1'b0, 32'hFFFF_0000,
                4'b0001, 4'h3, 1'b0, 1'b0, 32'h0, 5, 4};

    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.cmd_strb  = '0;
    bus.PREADY    = '0;
    bus.PSLVERR   = '0;
    bus.PRDATA    = '0;

    #2;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_reset_before_edge cmd_ready", 64'(bus.cmd_ready), 64'(0));
    @(negedge clk);
    check("post_reset_first_edge cmd_ready", 64'(bus.cmd_ready), 64'(1));

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset pulsed while a write to completer 2 is stuck in ACCESS.
    @(negedge clk);
    bus.PREADY    = '0;
    bus.PSLVERR   = '0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 32'h0000_2000;
    bus.cmd_wdata = 32'h600D_600D;
    bus.cmd_strb  = 4'hF;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    check("rst_mid pre_access", 64'({bus.PSEL, bus.PENABLE}), 64'({4'b0100, 1'b1}));
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    bus.PREADY = '1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b0 || bus.PSEL !== '0) seen++;
    end
    check("rst_mid no_rsp_after", 64'(seen), 64'(0));
    run_vec(vecs[0], "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/apb_requester.md
APB_REQUESTER -- requirements
Module: apb_requester

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, PADDR width.
REQ-002 SHALL have parameter DATA_W, default 32, data width in bits; legal values 8, 16, 32, 64.
REQ-003 SHALL have parameter NUM_SLV, default 4, number of completers; legal range 1-16.
REQ-004 SHALL have parameter SLV_AW, default 12, log2 of the region size, in bytes, given to each completer.
REQ-005 SHALL have parameter TIMEOUT, default 16, maximum wait-state count; 0 disables the timeout.
REQ-006 SHALL use one clock and an asynchronous, active-high reset.
REQ-007 SHALL have port PCLK, input, width 1: sole clock, rising edge.
REQ-008 SHALL have port PRESET, input, width 1: asynchronous active-high reset.
REQ-009 SHALL have port cmd_valid, input, width 1: command request.
REQ-010 SHALL have port cmd_ready, output, width 1: command accepted when sampled high together with cmd_valid.
REQ-011 SHALL have port cmd_write, input, width 1: 1 = write, 0 = read.
REQ-012 SHALL have port cmd_addr, input, width ADDR_W: byte address.
REQ-013 SHALL have port cmd_wdata, input, width DATA_W: write data.
REQ-014 SHALL have port cmd_strb, input, width DATA_W/8: byte-lane enables for writes.
REQ-015 SHALL have port rsp_valid, output, width 1: one-cycle response pulse; there is no backpressure.
REQ-016 SHALL have port rsp_rdata, output, width DATA_W: read data.
REQ-017 SHALL have port rsp_err, output, width 1: PSLVERR, decode error or timeout.
REQ-018 SHALL have port rsp_timeout, output, width 1: the error was caused by a timeout.
REQ-019 SHALL have the following APB requester outputs:
- PSEL, width NUM_SLV, one-hot completer select.
- PENABLE, width 1.
- PADDR, width ADDR_W.
- PWRITE, width 1.
- PWDATA, width DATA_W.
- PSTRB, width DATA_W/8.
REQ-020 SHALL have the following APB completer inputs:
- PREADY, width NUM_SLV.
- PSLVERR, width NUM_SLV.
- PRDATA, width NUM_SLV*DATA_W; completer i occupies bits [i*DATA_W +: DATA_W].

Function
REQ-021 SHALL implement states IDLE, SETUP, ACCESS and DECERR; all outputs SHALL be registered.
REQ-022 SHALL drive cmd_ready=1 only in IDLE.
REQ-023 SHALL compute the decode index as idx = cmd_addr[SLV_AW +: clog2(NUM_SLV)].
REQ-024 SHALL decode a command as a decode error if idx >= NUM_SLV or any cmd_addr bit above the index field is 1.
REQ-025 SHALL, on acceptance of a command that decodes, go IDLE->SETUP and capture address, data, write and strobe into PADDR, PWDATA, PWRITE, PSTRB.
REQ-026 SHALL, in SETUP, drive PSEL[idx]=1 and PENABLE=0, then move to ACCESS on the next edge.
REQ-027 SHALL, in ACCESS, drive PSEL[idx]=1 and PENABLE=1, and hold PADDR, PWRITE, PWDATA and PSTRB stable.
REQ-028 SHALL complete an ACCESS in the cycle where PREADY[idx]=1, then on the next cycle:
- go to IDLE;
- pulse rsp_valid;
- set rsp_err=PSLVERR[idx] and rsp_timeout=0;
- set rsp_rdata=PRDATA[idx] for reads, 0 for writes.
REQ-029 SHALL force PSTRB=0 for reads regardless of cmd_strb.
REQ-030 SHALL have a zero-wait-state latency of 3 cycles: accept at edge k, SETUP at k+1, ACCESS at k+2, rsp_valid at k+3.
REQ-031 SHALL, on a command that does not decode, go to DECERR for one cycle with PSEL all-zero, then pulse rsp_valid with rsp_err=1, rsp_timeout=0, rsp_rdata=0, and return to IDLE.
REQ-032 SHALL count ACCESS cycles with PREADY[idx]=0 in a wait counter of width clog2(TIMEOUT+1), cleared on entry to SETUP.
REQ-033 SHALL, when TIMEOUT>0 and the wait counter reaches TIMEOUT:
- deassert PSEL and PENABLE on the next edge;
- pulse rsp_valid with rsp_err=1, rsp_timeout=1, rsp_rdata=0;
- go to IDLE.
REQ-034 SHALL ignore PREADY, PSLVERR and PRDATA of unselected completers, and of all completers outside ACCESS.
REQ-035 SHALL ignore cmd_* inputs when cmd_ready=0.
REQ-036 SHALL, when TIMEOUT=0, wait indefinitely in ACCESS.

Reset
REQ-037 SHALL, while PRESET=1, immediately (asynchronously) force:
- state=IDLE and wait counter=0;
- PSEL=0, PENABLE=0, PADDR=0, PWRITE=0, PWDATA=0, PSTRB=0;
- rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0;
- cmd_ready=0.
REQ-038 SHALL drive cmd_ready=1 from the first edge after PRESET deasserts.
REQ-039 SHALL, on reset mid-transfer, abort the transfer with no rsp_valid, now or after reset.

Verification
REQ-040 SHALL cover a zero-wait write with default parameters:
- stimulus: addr 0x1004, data 0xA5A5_5A5A, strb 0xF, PREADY[1] tied to 1;
- response: PSEL=4'b0010 for 2 cycles, PENABLE in the 2nd cycle, PSTRB=0xF, rsp_valid 3 cycles after accept, rsp_err=0.
REQ-041 SHALL cover a read with 3 wait states:
- stimulus: addr 0x2010, PRDATA[2]=0xDEAD_BEEF, PREADY[2] high on the 4th ACCESS cycle;
- response: PSTRB=0, rsp_rdata=0xDEAD_BEEF, rsp_valid 6 cycles after accept.
REQ-042 SHALL cover a decode error:
- stimulus: addr 0x4000 with NUM_SLV=4;
- response: PSEL stays 0, rsp_valid with rsp_err=1 and rsp_timeout=0 two cycles after accept.
REQ-043 SHALL cover a timeout:
- stimulus: PREADY held 0, TIMEOUT=16;
- response: rsp_err=1, rsp_timeout=1, PSEL and PENABLE dropped after 16 wait cycles, cmd_ready=1 again.
REQ-044 SHALL cover PSLVERR:
- stimulus: write completes with PSLVERR[3]=1;
- response: rsp_err=1, rsp_timeout=0.
REQ-045 SHALL cover reset mid-transfer:
- stimulus: PRESET pulsed during ACCESS;
- response: all outputs 0 in the same cycle, no rsp_valid, next command completes normally.
